// File: rtl/sram_arbiter_if.sv
// Request/response bus of sram_arbiter: display reads, game-logic
// writes and the strobe/address/data side toward the SRAM controller.
`timescale 1ns/1ps
interface sram_arbiter_if;
  logic        rd_req;
  logic [8:0]  rd_x;
  logic [8:0]  rd_y;
  logic        rd_ready;
  logic [5:0]  rd_data;
  logic        rd_valid;
  logic        wr_req;
  logic [8:0]  wr_x;
  logic [8:0]  wr_y;
  logic [5:0]  wr_data;
  logic        wr_ready;
  logic        wr_ack;
  logic        read;
  logic        write;
  logic [8:0]  mem_addr_x;
  logic [8:0]  mem_addr_y;
  logic [15:0] data_to_write;
  logic [15:0] sram_rdata;

  modport slave (
    input  rd_req, rd_x, rd_y,
    input  wr_req, wr_x, wr_y, wr_data,
    input  sram_rdata,
    output rd_ready, rd_data, rd_valid,
    output wr_ready, wr_ack,
    output read, write,
    output mem_addr_x, mem_addr_y,
    output data_to_write
  );

  modport master (
    output rd_req, rd_x, rd_y,
    output wr_req, wr_x, wr_y, wr_data,
    output sram_rdata,
    input  rd_ready, rd_data, rd_valid,
    input  wr_ready, wr_ack,
    input  read, write,
    input  mem_addr_x, mem_addr_y,
    input  data_to_write
  );
endinterface

// File: rtl/sram_arbiter.sv
// Two-port framebuffer SRAM arbiter: display reads vs game writes,
// alternating priority on contention, out-of-range accesses muted.
`timescale 1ns/1ps
module sram_arbiter #(
  parameter int FB_W = 400,
  parameter int FB_H = 300
) (
  input logic           clk,
  input logic           rst_n,
  sram_arbiter_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE, RD1, RD2, WR_SETUP, WR_PULSE, WR_HOLD
  } state_t;

  localparam logic [9:0] W_LIM = 10'(FB_W);
  localparam logic [9:0] H_LIM = 10'(FB_H);

  state_t      state_q;
  state_t      state_d;
  logic        live_q;
  logic        prefer_wr_q;
  logic        rd_oor_q;
  logic        wr_oor_q;
  logic        rd_valid_q;
  logic [5:0]  rd_data_q;
  logic [8:0]  addr_x_q;
  logic [8:0]  addr_y_q;
  logic [15:0] wdata_q;

  logic ready;
  logic rd_acc;
  logic wr_acc;
  logic take_rd;
  logic take_wr;
  logic rd_oor;
  logic wr_oor;
  logic rd_stb;
  logic wr_stb;
  logic ack;
  logic unused_rdata;

  // live_q keeps ready low until the first edge after reset
  assign ready   = live_q && (state_q == IDLE);
  assign rd_acc  = bus.rd_req && ready;
  assign wr_acc  = bus.wr_req && ready;
  assign take_wr = wr_acc && (!rd_acc || prefer_wr_q);
  assign take_rd = rd_acc && !take_wr;

  assign rd_oor = ({1'b0, bus.rd_x} >= W_LIM) ||
                  ({1'b0, bus.rd_y} >= H_LIM);
  assign wr_oor = ({1'b0, bus.wr_x} >= W_LIM) ||
                  ({1'b0, bus.wr_y} >= H_LIM);

  assign unused_rdata = ^bus.sram_rdata[15:6];

  always_comb begin
    state_d = state_q;
    rd_stb  = 1'b0;
    wr_stb  = 1'b0;
    ack     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (take_rd)      state_d = RD1;
        else if (take_wr) state_d = WR_SETUP;
      end
      RD1: begin
        state_d = RD2;
        rd_stb  = !rd_oor_q;
      end
      RD2: begin
        state_d = IDLE;
        rd_stb  = !rd_oor_q;
      end
      WR_SETUP: state_d = WR_PULSE;
      WR_PULSE: begin
        state_d = WR_HOLD;
        wr_stb  = !wr_oor_q;
      end
      WR_HOLD: begin
        state_d = IDLE;
        ack     = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      live_q      <= 1'b0;
      prefer_wr_q <= 1'b0;
      rd_oor_q    <= 1'b0;
      wr_oor_q    <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      addr_x_q    <= '0;
      addr_y_q    <= '0;
      wdata_q     <= '0;
    end else begin
      live_q     <= 1'b1;
      state_q    <= state_d;
      rd_valid_q <= (state_q == RD2);
      if (take_rd) begin
        addr_x_q <= bus.rd_x;
        addr_y_q <= bus.rd_y;
        rd_oor_q <= rd_oor;
      end
      if (take_wr) begin
        addr_x_q <= bus.wr_x;
        addr_y_q <= bus.wr_y;
        wdata_q  <= {10'b0, bus.wr_data};
        wr_oor_q <= wr_oor;
      end
      // a write still waiting when a read retires goes first next time
      if (state_q == RD2) begin
        rd_data_q   <= rd_oor_q ? 6'd0 : bus.sram_rdata[5:0];
        prefer_wr_q <= bus.wr_req;
      end
      if (state_q == WR_HOLD) prefer_wr_q <= 1'b0;
    end
  end

  assign bus.rd_ready      = ready;
  assign bus.wr_ready      = ready;
  assign bus.rd_valid      = rd_valid_q;
  assign bus.rd_data       = rd_data_q;
  assign bus.wr_ack        = ack;
  assign bus.read          = rd_stb;
  assign bus.write         = wr_stb;
  assign bus.mem_addr_x    = addr_x_q;
  assign bus.mem_addr_y    = addr_y_q;
  assign bus.data_to_write = wdata_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: stimulus queues expected
// completions, a negedge monitor retires them on rd_valid/wr_ack.
`timescale 1ns/1ps
module tb_sram_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sram_arbiter_if bus();

  sram_arbiter #(.FB_W(400), .FB_H(300)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    bit         is_wr;
    logic [8:0] x;
    logic [8:0] y;
    logic [15:0] d;
    int         n;
    bit         chk_addr;
  } exp_t;

  exp_t exp_q[$];
  exp_t me;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rcnt = 0;
  int wcnt = 0;
  int rcyc = 0;
  int wcyc = 0;
  int w_total = 0;
  int ack_total = 0;
  bit rchg = 0;
  bit overlap = 0;
  logic [8:0] sx, sy;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  function automatic void push(input bit w, input logic [8:0] x,
                               input logic [8:0] y, input logic [15:0] d,
                               input int n, input bit ca);
    exp_t e;
    e.is_wr = w;
    e.x = x;
    e.y = y;
    e.d = d;
    e.n = n;
    e.chk_addr = ca;
    exp_q.push_back(e);
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (bus.write) w_total++;
    if (bus.wr_ack) ack_total++;
    if (!rst_n) begin
      rcnt = 0;
      wcnt = 0;
      rchg = 0;
    end else begin
      if (bus.read && bus.write) overlap = 1;
      if (bus.read) begin
        rcnt++;
        rcyc = cyc;
        if (rcnt == 1) begin
          sx = bus.mem_addr_x;
          sy = bus.mem_addr_y;
        end else if (bus.mem_addr_x != sx || bus.mem_addr_y != sy) begin
          rchg = 1;
        end
      end
      if (bus.write) begin
        wcnt++;
        wcyc = cyc;
      end
      if (bus.rd_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_rd_valid: got 1 want 0");
        end else begin
          me = exp_q.pop_front();
          chk("rd_kind", 32'(me.is_wr), 32'd0);
          chk("rd_data", 32'(bus.rd_data), 32'(me.d[5:0]));
          chk("rd_pulses", 32'(rcnt), 32'(me.n));
          if (me.n > 0) begin
            chk("rd_latency", 32'(cyc - rcyc), 32'd1);
            chk("rd_addr_x", 32'(sx), 32'(me.x));
            chk("rd_addr_y", 32'(sy), 32'(me.y));
            chk("rd_addr_stable", 32'(rchg), 32'd0);
          end
          if (me.chk_addr) begin
            chk("rd_addr_hold_x", 32'(bus.mem_addr_x), 32'(me.x));
            chk("rd_addr_hold_y", 32'(bus.mem_addr_y), 32'(me.y));
          end
        end
        rcnt = 0;
        rchg = 0;
      end
      if (bus.wr_ack) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_wr_ack: got 1 want 0");
        end else begin
          me = exp_q.pop_front();
          chk("wr_kind", 32'(me.is_wr), 32'd1);
          chk("wr_pulses", 32'(wcnt), 32'(me.n));
          if (me.n > 0) chk("wr_pulse_pos", 32'(cyc - wcyc), 32'd1);
          chk("wr_data", 32'(bus.data_to_write), 32'(me.d));
          if (me.chk_addr) begin
            chk("wr_addr_x", 32'(bus.mem_addr_x), 32'(me.x));
            chk("wr_addr_y", 32'(bus.mem_addr_y), 32'(me.y));
          end
        end
        wcnt = 0;
      end
    end
  end

  task automatic run(input int nr, input int nw, input bit mut);
    int rs = 0;
    int ws = 0;
    bit done_mut = 0;
    bus.rd_req = (nr > 0);
    bus.wr_req = (nw > 0);
    for (int i = 0; i < 200 && (rs < nr || ws < nw); i++) begin
      @(negedge clk);
      if (mut && !done_mut && bus.read) begin
        bus.rd_x = 9'd50;
        bus.rd_y = 9'd60;
        done_mut = 1;
      end
      if (bus.rd_valid) begin
        rs++;
        if (rs >= nr) bus.rd_req = 1'b0;
      end
      if (bus.wr_ack) begin
        ws++;
        if (ws >= nw) bus.wr_req = 1'b0;
      end
    end
    chk("run_done", 32'(rs >= nr && ws >= nw), 32'd1);
    bus.rd_req = 1'b0;
    bus.wr_req = 1'b0;
  endtask

  task automatic chk_rst(input string t);
    chk({t, "_read"}, 32'(bus.read), 32'd0);
    chk({t, "_write"}, 32'(bus.write), 32'd0);
    chk({t, "_rd_valid"}, 32'(bus.rd_valid), 32'd0);
    chk({t, "_wr_ack"}, 32'(bus.wr_ack), 32'd0);
    chk({t, "_rd_data"}, 32'(bus.rd_data), 32'd0);
    chk({t, "_addr_x"}, 32'(bus.mem_addr_x), 32'd0);
    chk({t, "_addr_y"}, 32'(bus.mem_addr_y), 32'd0);
    chk({t, "_wdata"}, 32'(bus.data_to_write), 32'd0);
    chk({t, "_rd_ready"}, 32'(bus.rd_ready), 32'd0);
    chk({t, "_wr_ready"}, 32'(bus.wr_ready), 32'd0);
  endtask

  task automatic release_rst(input string t);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk({t, "_ready_pre"}, 32'(bus.rd_ready), 32'd0);
    @(negedge clk);
    chk({t, "_rd_ready_up"}, 32'(bus.rd_ready), 32'd1);
    chk({t, "_wr_ready_up"}, 32'(bus.wr_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, a0;
    bus.rd_req = 0;
    bus.rd_x = 0;
    bus.rd_y = 0;
    bus.wr_req = 0;
    bus.wr_x = 0;
    bus.wr_y = 0;
    bus.wr_data = 0;
    bus.sram_rdata = 0;

    repeat (3) @(negedge clk);
    chk_rst("rst");
    release_rst("rel");

    bus.rd_x = 9'd10;
    bus.rd_y = 9'd20;
    bus.sram_rdata = 16'h002A;
    push(0, 9'd10, 9'd20, 16'h002A, 2, 1);
    run(1, 0, 0);

    bus.wr_x = 9'd399;
    bus.wr_y = 9'd299;
    bus.wr_data = 6'h15;
    push(1, 9'd399, 9'd299, 16'h0015, 1, 1);
    run(0, 1, 0);

    bus.rd_x = 9'd5;
    bus.rd_y = 9'd6;
    bus.sram_rdata = 16'hFF3C;
    bus.wr_x = 9'd7;
    bus.wr_y = 9'd8;
    bus.wr_data = 6'h2A;
    push(0, 9'd5, 9'd6, 16'h003C, 2, 1);
    push(1, 9'd7, 9'd8, 16'h002A, 1, 1);
    push(0, 9'd5, 9'd6, 16'h003C, 2, 1);
    push(1, 9'd7, 9'd8, 16'h002A, 1, 1);
    run(2, 2, 0);

    bus.rd_x = 9'd400;
    bus.rd_y = 9'd3;
    bus.sram_rdata = 16'h0033;
    push(0, 9'd0, 9'd0, 16'h0000, 0, 0);
    run(1, 0, 0);

    bus.wr_x = 9'd1;
    bus.wr_y = 9'd300;
    bus.wr_data = 6'h3F;
    push(1, 9'd0, 9'd0, 16'h003F, 0, 0);
    run(0, 1, 0);

    bus.rd_x = 9'd30;
    bus.rd_y = 9'd40;
    bus.sram_rdata = 16'h0007;
    push(0, 9'd30, 9'd40, 16'h0007, 2, 1);
    run(1, 0, 1);

    w0 = w_total;
    a0 = ack_total;
    @(negedge clk);
    bus.wr_x = 9'd3;
    bus.wr_y = 9'd4;
    bus.wr_data = 6'h11;
    bus.wr_req = 1'b1;
    @(posedge clk);
    #1;
    bus.wr_req = 1'b0;
    chk("abort_in_setup", 32'(bus.wr_ready), 32'd0);
    #1;
    rst_n = 1'b0;
    #1;
    chk_rst("abort");
    repeat (3) @(negedge clk);
    release_rst("rel2");
    repeat (4) @(negedge clk);
    chk("abort_no_write", 32'(w_total - w0), 32'd0);
    chk("abort_no_ack", 32'(ack_total - a0), 32'd0);

    bus.rd_x = 9'd0;
    bus.rd_y = 9'd0;
    bus.sram_rdata = 16'h0001;
    push(0, 9'd0, 9'd0, 16'h0001, 2, 1);
    run(1, 0, 0);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("rw_overlap", 32'(overlap), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameters SHALL be: FB_W, default 400, visible width in cells; FB_H, default 300, visible height in cells.
REQ-002 Ports SHALL be, clock and reset first:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- rd_req  in  1  pixel read request (display side).
- rd_x, rd_y  in  9 each  read cell coordinates.
- rd_ready  out  1  arbiter can accept a read.
- rd_data  out  6  read cell value.
- rd_valid  out  1  rd_data valid, one-cycle pulse.
- wr_req  in  1  cell write request (game logic side).
- wr_x, wr_y  in  9 each  write cell coordinates.
- wr_data  in  6  value to write.
- wr_ready  out  1  arbiter can accept a write.
- wr_ack  out  1  write retired, one-cycle pulse.
- read  out  1  SRAM read strobe to controller.
- write  out  1  SRAM write strobe to controller.
- mem_addr_x, mem_addr_y  out  9 each  SRAM cell address to controller.
- data_to_write  out  16  write word to controller.
- sram_rdata  in  16  data bus as sampled from the SRAM.
REQ-003 Clock and reset SHALL be one clock, clk, and asynchronous active-low reset, rst_n.

Function
REQ-004 FSM states SHALL be IDLE, RD1, RD2, WR_SETUP, WR_PULSE, WR_HOLD.
REQ-005 rd_ready and wr_ready SHALL both be high only in IDLE; a request is accepted on a rising edge where req=1 and ready=1.
REQ-006 Accepted coordinates and data SHALL be registered at acceptance; later changes to the inputs SHALL NOT affect the transaction in flight.
REQ-007 Read sequence SHALL be: IDLE -> RD1 -> RD2 -> IDLE.
- read=1 in RD1 and RD2.
- Address is driven from the registers.
- sram_rdata[5:0] is captured into rd_data on the RD2 -> IDLE edge.
- rd_valid=1 for exactly the following cycle.
- Latency is 3 cycles from the acceptance edge to rd_valid.
REQ-008 Write sequence SHALL be: IDLE -> WR_SETUP -> WR_PULSE -> WR_HOLD -> IDLE.
- write=1 only in WR_PULSE; read=0 in all three states.
- Address and data_to_write = {10'b0, wr_data} are stable through all three states.
- wr_ack=1 for exactly one cycle, during WR_HOLD.
REQ-009 In IDLE, read and write SHALL be 0, and address and data_to_write SHALL hold their last values.
REQ-010 read and write SHALL never be high in the same cycle.
REQ-011 If rd_req and wr_req are accepted on the same edge, the read SHALL win, unless the previous completed transaction was a read and wr_req was already pending then, in which case the write SHALL win. This alternates priority and prevents starvation.
REQ-012 A losing request SHALL remain un-accepted; the requester SHALL hold req and its fields until accepted. No internal queue exists.
REQ-013 Out-of-range reads (rd_x >= FB_W or rd_y >= FB_H):
- No SRAM access: read stays 0.
- Same 3-cycle timing.
- rd_data = 0.
REQ-014 Out-of-range writes (wr_x >= FB_W or wr_y >= FB_H):
- No write pulse: write stays 0.
- wr_ack still pulses on the same timing, so the transaction completes silently.
REQ-015 Coordinates SHALL pass through unmodified, with no wrap-around. The address space is 9+9 bits, with y as the high half.

Reset
REQ-016 While rst_n=0, outputs SHALL be:
- state IDLE; read=0; write=0.
- rd_valid=0; wr_ack=0.
- rd_data=0; mem_addr_x=0; mem_addr_y=0; data_to_write=0.
- rd_ready=0 and wr_ready=0.
REQ-017 After rst_n deasserts, rd_ready and wr_ready SHALL rise on the first clk edge.
REQ-018 Reset asserted mid-transaction SHALL abort it immediately; no ack or valid is produced and the priority history is cleared to read-first.

Verification
REQ-019 Bench SHALL cover read: rd_x=10, rd_y=20, sram_rdata=16'h002A -> read=1 for 2 cycles at address (10,20); rd_valid pulse 3 cycles after acceptance with rd_data=6'h2A.
REQ-020 Bench SHALL cover write: wr_x=399, wr_y=299, wr_data=6'h15 -> one write pulse in the middle cycle with data_to_write=16'h0015; wr_ack in the third cycle.
REQ-021 Bench SHALL cover simultaneous requests: rd_req and wr_req together from IDLE after a write -> read first, then write; with both held continuously -> strict read/write alternation.
REQ-022 Bench SHALL cover out-of-range: rd_x=400 -> rd_data=0, read never 1; wr_y=300 -> wr_ack pulses, write never 1.
REQ-023 Bench SHALL cover reset abort: rst_n low during WR_SETUP -> write never 1, no wr_ack; all outputs at reset values the same cycle.
REQ-024 Bench SHALL cover input changes: rd_x/rd_y changed during RD1 -> address unchanged until IDLE.
